// File: rtl/elastic_fifo_prefill_pkg.sv
`default_nettype none
// ============================================================================
// Module      : elastic_fifo_prefill_pkg
// Description : Shared helpers for the prefill elastic FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
package elastic_fifo_prefill_pkg;

   // A prefill level of zero would never arm reads meaningfully, so it is
   // promoted to one: the first stored word enables streaming.
   function automatic int unsigned prefill_threshold(input int unsigned level);
      return (level == 32'd0) ? 32'd1 : level;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ram_sdp_dist.sv
`default_nettype none
// ============================================================================
// Module      : ram_sdp_dist
// Description : Simple dual-port distributed storage. Synchronous write,
//               asynchronous read; no reset on the array contents.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_sdp_dist #(
   parameter int WIDTH = 16,
   parameter int ADDR  = 4
) (
   input  logic             clk,
   input  logic             we,
   input  logic [ADDR-1:0]  waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [ADDR-1:0]  raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] r_mem [(1 << ADDR)];

   // Store the write word on the clock edge
   always_ff @(posedge clk) begin
      if (we) begin
         r_mem[waddr] <= wdata;
      end
   end

   // Read port is combinational; the parent registers the result
   always_comb begin
      rdata = r_mem[raddr];
   end

endmodule
`default_nettype wire

// File: rtl/elastic_fifo_prefill.sv
`default_nettype none
// ============================================================================
// Module      : elastic_fifo_prefill
// Description : Single-clock elastic FIFO that withholds reads until a
//               run-time prefill level is reached, then streams with a
//               registered output. Sticky overrun/underrun flags, optional
//               re-arm of the prefill after an underrun.
// Revision    : 1.0 - initial release
// ============================================================================
module elastic_fifo_prefill
   import elastic_fifo_prefill_pkg::*;
#(
   parameter int                    DATA_WIDTH        = 16,
   parameter int                    DATA_DEPTH        = 4,
   parameter logic [DATA_WIDTH-1:0] INITIAL_VALUE     = '0,
   parameter int                    REARM_ON_UNDERRUN = 1
) (
   input  logic                  clk,
   input  logic                  srst,
   input  logic                  we,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  re,
   input  logic [DATA_DEPTH-1:0] prefill,
   input  logic                  clr_err,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  rd_stb,
   output logic                  valid,
   output logic [DATA_DEPTH:0]   fill,
   output logic                  overrun,
   output logic                  underrun
);

   typedef logic [DATA_DEPTH:0] fill_t;

   localparam int    C_CAPACITY = 1 << DATA_DEPTH;
   localparam fill_t C_FULL     = fill_t'(C_CAPACITY);

   logic [DATA_DEPTH-1:0] r_waddr;
   logic [DATA_DEPTH-1:0] r_raddr;
   logic [DATA_WIDTH-1:0] w_rdata;
   logic                  w_full;
   logic                  w_empty;
   logic                  w_rd_acc;
   logic                  w_wr_acc;
   logic                  w_overrun_evt;
   logic                  w_underrun_evt;
   logic                  w_rearm;
   fill_t                 w_thresh;
   fill_t                 w_fill_next;
   logic                  w_valid_next;

   // Accept/reject decisions for this cycle and the resulting fill/valid
   always_comb begin
      w_full         = (fill == C_FULL);
      w_empty        = (fill == '0);
      w_rd_acc       = re & valid & ~w_empty;
      // A read in the same cycle frees a slot, so a full FIFO still accepts
      w_wr_acc       = we & (~w_full | w_rd_acc);
      w_overrun_evt  = we & w_full & ~w_rd_acc;
      // Deliberately no write-to-read bypass when empty
      w_underrun_evt = re & valid & w_empty;
      w_rearm        = (REARM_ON_UNDERRUN != 0) && w_underrun_evt;
      w_thresh       = fill_t'(prefill_threshold(32'(prefill)));

      w_fill_next = fill;
      if (w_wr_acc && !w_rd_acc) begin
         w_fill_next = fill + fill_t'(1);
      end else if (!w_wr_acc && w_rd_acc) begin
         w_fill_next = fill - fill_t'(1);
      end

      // Once armed, prefill changes are ignored; re-arming underrun wins
      w_valid_next = valid;
      if (w_rearm) begin
         w_valid_next = 1'b0;
      end else if (!valid && (w_fill_next >= w_thresh)) begin
         w_valid_next = 1'b1;
      end
   end

   ram_sdp_dist #(
      .WIDTH (DATA_WIDTH),
      .ADDR  (DATA_DEPTH)
   ) u_ram (
      .clk   (clk),
      .we    (w_wr_acc & ~srst),
      .waddr (r_waddr),
      .wdata (data_in),
      .raddr (r_raddr),
      .rdata (w_rdata)
   );

   // Pointers, fill, arming, output register and sticky flags
   always_ff @(posedge clk) begin
      if (srst) begin
         r_waddr  <= '0;
         r_raddr  <= '0;
         fill     <= '0;
         valid    <= 1'b0;
         rd_stb   <= 1'b0;
         overrun  <= 1'b0;
         underrun <= 1'b0;
         data_out <= INITIAL_VALUE;
      end else begin
         if (w_wr_acc) begin
            r_waddr <= r_waddr + 1'b1;
         end
         if (w_rd_acc) begin
            r_raddr  <= r_raddr + 1'b1;
            data_out <= w_rdata;
         end
         fill     <= w_fill_next;
         valid    <= w_valid_next;
         rd_stb   <= w_rd_acc;
         // A fresh error in the clearing cycle keeps its flag set
         overrun  <= w_overrun_evt  | (overrun  & ~clr_err);
         underrun <= w_underrun_evt | (underrun & ~clr_err);
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_elastic_fifo_prefill.sv
`default_nettype none
// ============================================================================
// Module      : tb_elastic_fifo_prefill
// Description : Directed self-checking bench for elastic_fifo_prefill. Two
//               instances share stimulus: one re-arms on underrun, one not.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_elastic_fifo_prefill;

   localparam logic [15:0] C_INIT = 16'hBEEF;

   logic        clk = 1'b0;
   logic        srst = 1'b0;
   logic        we = 1'b0;
   logic [15:0] data_in = '0;
   logic        re = 1'b0;
   logic [3:0]  prefill = '0;
   logic        clr_err = 1'b0;

   logic [15:0] data_out,  data_out0;
   logic        rd_stb,    rd_stb0;
   logic        valid,     valid0;
   logic [4:0]  fill,      fill0;
   logic        overrun,   overrun0;
   logic        underrun,  underrun0;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   elastic_fifo_prefill #(
      .DATA_WIDTH (16), .DATA_DEPTH (4), .INITIAL_VALUE (C_INIT), .REARM_ON_UNDERRUN (1)
   ) u_dut (
      .clk (clk), .srst (srst), .we (we), .data_in (data_in), .re (re),
      .prefill (prefill), .clr_err (clr_err), .data_out (data_out),
      .rd_stb (rd_stb), .valid (valid), .fill (fill),
      .overrun (overrun), .underrun (underrun)
   );

   elastic_fifo_prefill #(
      .DATA_WIDTH (16), .DATA_DEPTH (4), .INITIAL_VALUE (C_INIT), .REARM_ON_UNDERRUN (0)
   ) u_dut0 (
      .clk (clk), .srst (srst), .we (we), .data_in (data_in), .re (re),
      .prefill (prefill), .clr_err (clr_err), .data_out (data_out0),
      .rd_stb (rd_stb0), .valid (valid0), .fill (fill0),
      .overrun (overrun0), .underrun (underrun0)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      srst = 1'b1; we = 1'b0; re = 1'b0; clr_err = 1'b0; data_in = '0;
      tick();
      srst = 1'b0;
   endtask

   task automatic test_reset;
      we = 1'b1; re = 1'b1; data_in = 16'h1234; prefill = 4'd1;
      srst = 1'b1;
      tick();
      srst = 1'b0; we = 1'b0; re = 1'b0;
      checks++; if (fill !== 5'd0)        begin errors++; $display("FAIL reset_fill got %0d want 0", fill); end
      checks++; if (valid !== 1'b0)       begin errors++; $display("FAIL reset_valid got %b want 0", valid); end
      checks++; if (rd_stb !== 1'b0)      begin errors++; $display("FAIL reset_rd_stb got %b want 0", rd_stb); end
      checks++; if (overrun !== 1'b0)     begin errors++; $display("FAIL reset_overrun got %b want 0", overrun); end
      checks++; if (underrun !== 1'b0)    begin errors++; $display("FAIL reset_underrun got %b want 0", underrun); end
      checks++; if (data_out !== C_INIT)  begin errors++; $display("FAIL reset_data_out got %h want %h", data_out, C_INIT); end
   endtask

   task automatic test_prefill;
      do_reset();
      prefill = 4'd8;
      for (int i = 0; i < 7; i++) begin
         we = 1'b1; re = 1'b1; data_in = 16'(16'h0100 + i);
         tick();
      end
      we = 1'b0; re = 1'b0;
      checks++; if (valid !== 1'b0)      begin errors++; $display("FAIL prefill7_valid got %b want 0", valid); end
      checks++; if (fill !== 5'd7)       begin errors++; $display("FAIL prefill7_fill got %0d want 7", fill); end
      checks++; if (rd_stb !== 1'b0)     begin errors++; $display("FAIL prefill7_rd_stb got %b want 0", rd_stb); end
      checks++; if (data_out !== C_INIT) begin errors++; $display("FAIL prefill7_data_out got %h want %h", data_out, C_INIT); end
      checks++; if (underrun !== 1'b0)   begin errors++; $display("FAIL prefill7_underrun got %b want 0", underrun); end
      we = 1'b1; data_in = 16'h0107;
      tick();
      we = 1'b0;
      checks++; if (valid !== 1'b1)      begin errors++; $display("FAIL prefill8_valid got %b want 1", valid); end
      checks++; if (fill !== 5'd8)       begin errors++; $display("FAIL prefill8_fill got %0d want 8", fill); end
   endtask

   task automatic test_back_to_back;
      do_reset();
      prefill = 4'd4;
      for (int i = 0; i < 4; i++) begin
         we = 1'b1; data_in = 16'(16'h0010 + i);
         tick();
      end
      we = 1'b0;
      checks++; if (valid !== 1'b1) begin errors++; $display("FAIL b2b_armed got %b want 1", valid); end
      for (int i = 0; i < 4; i++) begin
         re = 1'b1;
         tick();
         checks++; if (data_out !== 16'(16'h0010 + i)) begin errors++; $display("FAIL b2b_data[%0d] got %h want %h", i, data_out, 16'(16'h0010 + i)); end
         checks++; if (rd_stb !== 1'b1) begin errors++; $display("FAIL b2b_rd_stb[%0d] got %b want 1", i, rd_stb); end
      end
      re = 1'b0;
      tick();
      checks++; if (rd_stb !== 1'b0)        begin errors++; $display("FAIL b2b_stb_end got %b want 0", rd_stb); end
      checks++; if (fill !== 5'd0)          begin errors++; $display("FAIL b2b_fill_end got %0d want 0", fill); end
      checks++; if (data_out !== 16'h0013)  begin errors++; $display("FAIL b2b_hold got %h want 0013", data_out); end
   endtask

   task automatic test_overrun;
      do_reset();
      prefill = 4'd15;
      for (int i = 0; i < 16; i++) begin
         we = 1'b1; data_in = 16'(i);
         tick();
      end
      checks++; if (fill !== 5'd16) begin errors++; $display("FAIL ovr_full_fill got %0d want 16", fill); end
      data_in = 16'hAAAA;
      tick();
      checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag got %b want 1", overrun); end
      checks++; if (fill !== 5'd16)   begin errors++; $display("FAIL ovr_fill got %0d want 16", fill); end
      // Clear request colliding with a fresh overrun
      data_in = 16'hBBBB; clr_err = 1'b1;
      tick();
      checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL clr_collide got %b want 1", overrun); end
      we = 1'b0;
      tick();
      clr_err = 1'b0;
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL clr_err got %b want 0", overrun); end
      // Simultaneous write and read while full
      we = 1'b1; re = 1'b1; data_in = 16'h5555;
      tick();
      we = 1'b0;
      checks++; if (fill !== 5'd16)       begin errors++; $display("FAIL full_wr_rd_fill got %0d want 16", fill); end
      checks++; if (data_out !== 16'h0000) begin errors++; $display("FAIL full_wr_rd_data got %h want 0000", data_out); end
      checks++; if (overrun !== 1'b0)     begin errors++; $display("FAIL full_wr_rd_flag got %b want 0", overrun); end
      for (int i = 1; i <= 16; i++) begin
         tick();
         checks++;
         if (data_out !== ((i == 16) ? 16'h5555 : 16'(i))) begin
            errors++; $display("FAIL ovr_drain[%0d] got %h want %h", i, data_out, ((i == 16) ? 16'h5555 : 16'(i)));
         end
      end
      re = 1'b0;
      checks++; if (fill !== 5'd0) begin errors++; $display("FAIL ovr_drain_fill got %0d want 0", fill); end
   endtask

   task automatic test_underrun;
      do_reset();
      prefill = 4'd2;
      we = 1'b1; data_in = 16'h0021; tick();
      data_in = 16'h0022; tick();
      we = 1'b0; re = 1'b1;
      tick(); tick();
      checks++; if (data_out !== 16'h0022) begin errors++; $display("FAIL und_last got %h want 0022", data_out); end
      tick();
      re = 1'b0;
      checks++; if (underrun !== 1'b1)     begin errors++; $display("FAIL und_flag got %b want 1", underrun); end
      checks++; if (valid !== 1'b0)        begin errors++; $display("FAIL und_rearm_valid got %b want 0", valid); end
      checks++; if (data_out !== 16'h0022) begin errors++; $display("FAIL und_hold got %h want 0022", data_out); end
      checks++; if (rd_stb !== 1'b0)       begin errors++; $display("FAIL und_stb got %b want 0", rd_stb); end
      checks++; if (underrun0 !== 1'b1)    begin errors++; $display("FAIL und0_flag got %b want 1", underrun0); end
      checks++; if (valid0 !== 1'b1)       begin errors++; $display("FAIL und0_valid got %b want 1", valid0); end
      // Write plus read while empty: no bypass, write still lands
      we = 1'b1; re = 1'b1; data_in = 16'h0031;
      tick();
      re = 1'b0;
      checks++; if (fill0 !== 5'd1)         begin errors++; $display("FAIL nobypass_fill got %0d want 1", fill0); end
      checks++; if (data_out0 !== 16'h0022) begin errors++; $display("FAIL nobypass_data got %h want 0022", data_out0); end
      checks++; if (rd_stb0 !== 1'b0)       begin errors++; $display("FAIL nobypass_stb got %b want 0", rd_stb0); end
      checks++; if (valid !== 1'b0)         begin errors++; $display("FAIL rearm_wait got %b want 0", valid); end
      data_in = 16'h0032;
      tick();
      we = 1'b0;
      checks++; if (valid !== 1'b1)  begin errors++; $display("FAIL rearm_valid got %b want 1", valid); end
      checks++; if (fill !== 5'd2)   begin errors++; $display("FAIL rearm_fill got %0d want 2", fill); end
      checks++; if (valid0 !== 1'b1) begin errors++; $display("FAIL norearm_valid got %b want 1", valid0); end
   endtask

   task automatic test_wrap;
      do_reset();
      prefill = 4'd0;
      we = 1'b1; data_in = 16'h1000;
      tick();
      checks++; if (valid !== 1'b1) begin errors++; $display("FAIL wrap_arm got %b want 1", valid); end
      for (int k = 1; k <= 40; k++) begin
         we = (k < 40); re = 1'b1; data_in = 16'(16'h1000 + 3 * k);
         tick();
         checks++;
         if (data_out !== 16'(16'h1000 + 3 * (k - 1)) || rd_stb !== 1'b1) begin
            errors++; $display("FAIL wrap[%0d] got %h/%b want %h/1", k, data_out, rd_stb, 16'(16'h1000 + 3 * (k - 1)));
         end
      end
      we = 1'b0; re = 1'b0;
      checks++; if (fill !== 5'd0)                  begin errors++; $display("FAIL wrap_fill got %0d want 0", fill); end
      checks++; if ({overrun, underrun} !== 2'b00)  begin errors++; $display("FAIL wrap_flags got %b want 00", {overrun, underrun}); end
   endtask

   task automatic test_srst_midstream;
      do_reset();
      prefill = 4'd1;
      we = 1'b1; data_in = 16'h0041; tick();
      we = 1'b0; re = 1'b1; tick();
      tick();
      re = 1'b0;
      checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL srst_pre_flag got %b want 1", underrun); end
      we = 1'b1; data_in = 16'h0042; tick();
      we = 1'b1; re = 1'b1; data_in = 16'h7777; srst = 1'b1;
      tick();
      srst = 1'b0; we = 1'b0;
      checks++; if (fill !== 5'd0)        begin errors++; $display("FAIL srst_fill got %0d want 0", fill); end
      checks++; if (valid !== 1'b0)       begin errors++; $display("FAIL srst_valid got %b want 0", valid); end
      checks++; if ({overrun, underrun} !== 2'b00) begin errors++; $display("FAIL srst_flags got %b want 00", {overrun, underrun}); end
      checks++; if (data_out !== C_INIT)  begin errors++; $display("FAIL srst_data got %h want %h", data_out, C_INIT); end
      checks++; if (rd_stb !== 1'b0)      begin errors++; $display("FAIL srst_stb got %b want 0", rd_stb); end
      tick();
      re = 1'b0;
      checks++; if (fill !== 5'd0 || rd_stb !== 1'b0) begin errors++; $display("FAIL srst_discard got fill %0d stb %b want 0/0", fill, rd_stb); end
   endtask

   initial begin
      tick();
      test_reset();
      test_prefill();
      test_back_to_back();
      test_overrun();
      test_underrun();
      test_wrap();
      test_srst_midstream();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
